// File: rtl/keypad_conditioner_if.sv
// Front-panel bundle between the raw switch inputs and the microwave controller.
// master: the side that drives the raw switches; slave: the conditioner.
interface keypad_conditioner_if;
  logic [9:0] raw_keys;
  logic       raw_startn;
  logic       raw_stopn;
  logic       raw_clearn;
  logic       raw_door_closed;
  logic [9:0] keypad;
  logic       startn;
  logic       stopn;
  logic       clearn;
  logic       door_closed;

  modport master (
    output raw_keys, raw_startn, raw_stopn, raw_clearn, raw_door_closed,
    input  keypad, startn, stopn, clearn, door_closed
  );

  modport slave (
    input  raw_keys, raw_startn, raw_stopn, raw_clearn, raw_door_closed,
    output keypad, startn, stopn, clearn, door_closed
  );
endinterface

// File: rtl/keypad_conditioner.sv
// keypad_conditioner: synchronises and debounces the 10-key pad, the
// start/stop/clear buttons and the door switch for the microwave controller.
// Every press yields exactly one registered, one-clock strobe.
// Optional macro KEYPAD_REPEAT_EN: auto-repeat of a held digit every
// REPEAT_CYCLES clocks (off by default, no repeat logic built).
module keypad_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8,
  parameter int REPEAT_CYCLES   = 16
) (
  input logic                 clock,
  input logic                 reset,
  keypad_conditioner_if.slave bus
);
  localparam int NUM_BTN = 3;  // 0 start, 1 stop, 2 clear
  localparam logic [CNT_W-1:0] DB = CNT_W'(DEBOUNCE_CYCLES);

  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 255 ||
      (1 << CNT_W) <= DEBOUNCE_CYCLES || REPEAT_CYCLES < 1) begin : g_bad_param
    $error("keypad_conditioner: illegal parameter combination");
  end

  // counters stop at the threshold instead of wrapping
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c >= DB) ? DB : c + 1'b1;
  endfunction

  typedef enum logic [1:0] {K_IDLE, K_ARM, K_HELD, K_RELEASE} kstate_t;
  typedef enum logic {B_UP, B_DOWN} bstate_t;

  logic [9:0]         key_s1_q, key_s2_q;
  logic [NUM_BTN-1:0] btn_s1_q, btn_s2_q;
  logic               door_s1_q, door_s2_q;

  // two-flop synchronisers; buttons idle high, door reads open after reset
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      key_s1_q  <= '0;
      key_s2_q  <= '0;
      btn_s1_q  <= '1;
      btn_s2_q  <= '1;
      door_s1_q <= 1'b0;
      door_s2_q <= 1'b0;
    end else begin
      key_s1_q  <= bus.raw_keys;
      key_s2_q  <= key_s1_q;
      btn_s1_q  <= {bus.raw_clearn, bus.raw_stopn, bus.raw_startn};
      btn_s2_q  <= btn_s1_q;
      door_s1_q <= bus.raw_door_closed;
      door_s2_q <= door_s1_q;
    end
  end

  // ---------------- keypad ----------------
  kstate_t          kst_q, kst_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [9:0]       cap_q, cap_d, keypad_q, keypad_d;
  logic             one_hot;

`ifdef KEYPAD_REPEAT_EN
  localparam int RPT_W = $clog2(REPEAT_CYCLES + 1);
  logic [RPT_W-1:0] rpt_q, rpt_d, rpt_inc;
  logic             rpt_off_q, rpt_off_d;
`endif

  // keypad FSM next state: capture a single key, hold it for the debounce
  // window, strobe once, then require a debounced all-released pad
  always_comb begin
    kst_d    = kst_q;
    cnt_d    = cnt_q;
    cap_d    = cap_q;
    keypad_d = '0;
    cnt_inc  = sat_inc(cnt_q);
    one_hot  = (key_s2_q != '0) && ((key_s2_q & (key_s2_q - 10'd1)) == '0);
`ifdef KEYPAD_REPEAT_EN
    rpt_d     = rpt_q;
    rpt_off_d = rpt_off_q;
    rpt_inc   = rpt_q + 1'b1;
`endif
    case (kst_q)
      K_IDLE: begin
        if (one_hot) begin
          cap_d = key_s2_q;
          cnt_d = CNT_W'(1);
          kst_d = K_ARM;
        end
      end
      K_ARM: begin
        if (key_s2_q == cap_q) begin
          cnt_d = cnt_inc;
          if (cnt_inc == DB) begin
            keypad_d = cap_q;
            kst_d    = K_HELD;
`ifdef KEYPAD_REPEAT_EN
            rpt_d     = '0;
            rpt_off_d = 1'b0;
`endif
          end
        end else begin
          cnt_d = '0;
          kst_d = K_IDLE;
        end
      end
      K_HELD: begin
        if (key_s2_q == '0) begin
          cnt_d = CNT_W'(1);
          kst_d = K_RELEASE;
        end
`ifdef KEYPAD_REPEAT_EN
        // any change from the captured key ends repeating for this hold
        else if (key_s2_q == cap_q && !rpt_off_q) begin
          if (rpt_inc == RPT_W'(REPEAT_CYCLES)) begin
            keypad_d = cap_q;
            rpt_d    = '0;
          end else begin
            rpt_d = rpt_inc;
          end
        end else if (key_s2_q != cap_q) begin
          rpt_off_d = 1'b1;
        end
`endif
      end
      K_RELEASE: begin
        if (key_s2_q == '0) begin
          cnt_d = cnt_inc;
          if (cnt_inc == DB) kst_d = K_IDLE;
        end else begin
          kst_d = K_HELD;
`ifdef KEYPAD_REPEAT_EN
          rpt_d     = '0;
          rpt_off_d = 1'b0;
`endif
        end
      end
      default: kst_d = K_IDLE;
    endcase
  end

  // keypad FSM state, shared counter, captured key and registered strobe
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      kst_q     <= K_IDLE;
      cnt_q     <= '0;
      cap_q     <= '0;
      keypad_q  <= '0;
`ifdef KEYPAD_REPEAT_EN
      rpt_q     <= '0;
      rpt_off_q <= 1'b0;
`endif
    end else begin
      kst_q     <= kst_d;
      cnt_q     <= cnt_d;
      cap_q     <= cap_d;
      keypad_q  <= keypad_d;
`ifdef KEYPAD_REPEAT_EN
      rpt_q     <= rpt_d;
      rpt_off_q <= rpt_off_d;
`endif
    end
  end

  // ---------------- buttons ----------------
  bstate_t                       bst_q [NUM_BTN];
  bstate_t                       bst_d [NUM_BTN];
  logic [NUM_BTN-1:0][CNT_W-1:0] bcnt_q, bcnt_d, binc;
  logic [NUM_BTN-1:0]            fire;
  logic                          startn_q, stopn_q, clearn_q;
  logic                          startn_d, stopn_d, clearn_d;

  // per-button debounce: count samples at the opposite level, flip at DB;
  // the UP->DOWN flip raises that button's fire bit
  always_comb begin
    for (int b = 0; b < NUM_BTN; b++) begin
      bst_d[b]  = bst_q[b];
      bcnt_d[b] = bcnt_q[b];
      fire[b]   = 1'b0;
      binc[b]   = sat_inc(bcnt_q[b]);
      if ((bst_q[b] == B_UP) ? !btn_s2_q[b] : btn_s2_q[b]) begin
        if (binc[b] == DB) begin
          fire[b]   = (bst_q[b] == B_UP);
          bst_d[b]  = (bst_q[b] == B_UP) ? B_DOWN : B_UP;
          bcnt_d[b] = '0;
        end else begin
          bcnt_d[b] = binc[b];
        end
      end else begin
        bcnt_d[b] = '0;
      end
    end
    // clear beats stop beats start; losers are dropped, not queued
    clearn_d = !fire[2];
    stopn_d  = !(fire[1] && !fire[2]);
    startn_d = !(fire[0] && !fire[1] && !fire[2]);
  end

  // button FSM state, counters and registered active-low strobes
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int b = 0; b < NUM_BTN; b++) bst_q[b] <= B_UP;
      bcnt_q   <= '0;
      startn_q <= 1'b1;
      stopn_q  <= 1'b1;
      clearn_q <= 1'b1;
    end else begin
      for (int b = 0; b < NUM_BTN; b++) bst_q[b] <= bst_d[b];
      bcnt_q   <= bcnt_d;
      startn_q <= startn_d;
      stopn_q  <= stopn_d;
      clearn_q <= clearn_d;
    end
  end

  assign bus.keypad      = keypad_q;
  assign bus.startn      = startn_q;
  assign bus.stopn       = stopn_q;
  assign bus.clearn      = clearn_q;
  assign bus.door_closed = door_s2_q;
endmodule

// File: tb/tb_keypad_conditioner.sv
// Directed vector bench for keypad_conditioner (default build, no repeat).
// Each table row holds inputs steady for n clocks and expects the given
// outputs after every one of those clocks.
module tb_keypad_conditioner;
  logic clock = 1'b0;
  logic reset = 1'b1;
  keypad_conditioner_if bus ();

  keypad_conditioner #(.DEBOUNCE_CYCLES(4), .CNT_W(8), .REPEAT_CYCLES(16)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [9:0] keys;
    logic [2:0] btnn;   // {clearn, stopn, startn}
    logic       door;
    int         n;
    logic [9:0] ek;
    logic [2:0] ebn;    // {clearn, stopn, startn}
    logic       ed;
  } vec_t;

  vec_t tbl[$];
  int   nvec = 0;
  int   nerr = 0;

  function automatic void add(logic [9:0] k, logic [2:0] b, logic d, int n,
                              logic [9:0] ek, logic [2:0] eb, logic ed);
    vec_t v;
    v.keys = k; v.btnn = b; v.door = d; v.n = n;
    v.ek = ek; v.ebn = eb; v.ed = ed;
    tbl.push_back(v);
  endfunction

  task automatic drive(logic [9:0] k, logic [2:0] b, logic d);
    bus.raw_keys        = k;
    bus.raw_clearn      = b[2];
    bus.raw_stopn       = b[1];
    bus.raw_startn      = b[0];
    bus.raw_door_closed = d;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(string name, int idx, logic [9:0] ek, logic [2:0] eb, logic ed);
    logic [13:0] got, exp;
    got = {bus.keypad, bus.clearn, bus.stopn, bus.startn, bus.door_closed};
    exp = {ek, eb, ed};
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s #%0d: got keypad=%b c/s/s_n=%b door=%b, want keypad=%b c/s/s_n=%b door=%b",
               name, idx, got[13:4], got[3:1], got[0], ek, eb, ed);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // door sync latency
    add(10'h000, 3'b111, 1'b1, 1,  10'h000, 3'b111, 1'b0);
    add(10'h000, 3'b111, 1'b1, 1,  10'h000, 3'b111, 1'b1);
    // clean press of digit 2: strobe after the 6th sampling edge, once only
    add(10'h004, 3'b111, 1'b1, 5,  10'h000, 3'b111, 1'b1);
    add(10'h004, 3'b111, 1'b1, 1,  10'h004, 3'b111, 1'b1);
    add(10'h004, 3'b111, 1'b1, 14, 10'h000, 3'b111, 1'b1);
    add(10'h000, 3'b111, 1'b1, 10, 10'h000, 3'b111, 1'b1);
    // bouncing digit 1, then stable
    add(10'h002, 3'b111, 1'b1, 1,  10'h000, 3'b111, 1'b1);
    add(10'h000, 3'b111, 1'b1, 2,  10'h000, 3'b111, 1'b1);
    add(10'h002, 3'b111, 1'b1, 2,  10'h000, 3'b111, 1'b1);
    add(10'h000, 3'b111, 1'b1, 1,  10'h000, 3'b111, 1'b1);
    add(10'h002, 3'b111, 1'b1, 5,  10'h000, 3'b111, 1'b1);
    add(10'h002, 3'b111, 1'b1, 1,  10'h002, 3'b111, 1'b1);
    add(10'h002, 3'b111, 1'b1, 4,  10'h000, 3'b111, 1'b1);
    add(10'h000, 3'b111, 1'b1, 8,  10'h000, 3'b111, 1'b1);
    // two keys held: nothing; dropping to digit 0 alone: one strobe
    add(10'h003, 3'b111, 1'b1, 20, 10'h000, 3'b111, 1'b1);
    add(10'h001, 3'b111, 1'b1, 5,  10'h000, 3'b111, 1'b1);
    add(10'h001, 3'b111, 1'b1, 1,  10'h001, 3'b111, 1'b1);
    add(10'h001, 3'b111, 1'b1, 4,  10'h000, 3'b111, 1'b1);
    add(10'h000, 3'b111, 1'b1, 8,  10'h000, 3'b111, 1'b1);
    // clear + start together: clear only, no second strobe while held
    add(10'h000, 3'b010, 1'b1, 5,  10'h000, 3'b111, 1'b1);
    add(10'h000, 3'b010, 1'b1, 1,  10'h000, 3'b011, 1'b1);
    add(10'h000, 3'b010, 1'b1, 14, 10'h000, 3'b111, 1'b1);
    add(10'h000, 3'b111, 1'b1, 8,  10'h000, 3'b111, 1'b1);
    // start alone after release
    add(10'h000, 3'b110, 1'b1, 5,  10'h000, 3'b111, 1'b1);
    add(10'h000, 3'b110, 1'b1, 1,  10'h000, 3'b110, 1'b1);
    add(10'h000, 3'b110, 1'b1, 4,  10'h000, 3'b111, 1'b1);
    add(10'h000, 3'b111, 1'b1, 8,  10'h000, 3'b111, 1'b1);
    // stop + start together: stop wins
    add(10'h000, 3'b100, 1'b1, 5,  10'h000, 3'b111, 1'b1);
    add(10'h000, 3'b100, 1'b1, 1,  10'h000, 3'b101, 1'b1);
    add(10'h000, 3'b100, 1'b1, 4,  10'h000, 3'b111, 1'b1);
    add(10'h000, 3'b111, 1'b1, 8,  10'h000, 3'b111, 1'b1);
    // stop low for only 3 clocks: below threshold
    add(10'h000, 3'b101, 1'b1, 3,  10'h000, 3'b111, 1'b1);
    add(10'h000, 3'b111, 1'b1, 8,  10'h000, 3'b111, 1'b1);
    // clear, short 3-clock release, press again: no second strobe
    add(10'h000, 3'b011, 1'b1, 5,  10'h000, 3'b111, 1'b1);
    add(10'h000, 3'b011, 1'b1, 1,  10'h000, 3'b011, 1'b1);
    add(10'h000, 3'b011, 1'b1, 2,  10'h000, 3'b111, 1'b1);
    add(10'h000, 3'b111, 1'b1, 3,  10'h000, 3'b111, 1'b1);
    add(10'h000, 3'b011, 1'b1, 10, 10'h000, 3'b111, 1'b1);
    add(10'h000, 3'b111, 1'b1, 8,  10'h000, 3'b111, 1'b1);
    // digit 9 and stop together: both strobes in the same cycle
    add(10'h200, 3'b101, 1'b1, 5,  10'h000, 3'b111, 1'b1);
    add(10'h200, 3'b101, 1'b1, 1,  10'h200, 3'b101, 1'b1);
    add(10'h200, 3'b101, 1'b1, 4,  10'h000, 3'b111, 1'b1);
    add(10'h000, 3'b111, 1'b1, 8,  10'h000, 3'b111, 1'b1);

    // reset state, held for 3 clocks
    drive(10'h000, 3'b111, 1'b0);
    #1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("reset", i, 10'h000, 3'b111, 1'b0);
    end
    reset = 1'b0;

    foreach (tbl[r]) begin
      drive(tbl[r].keys, tbl[r].btnn, tbl[r].door);
      for (int c = 0; c < tbl[r].n; c++) begin
        tick();
        check("row", r, tbl[r].ek, tbl[r].ebn, tbl[r].ed);
      end
    end

    // reset in the middle of a press of digit 7, key still held afterwards
    drive(10'h080, 3'b111, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("prereset", i, 10'h000, 3'b111, 1'b1);
    end
    reset = 1'b1;
    #1;
    check("midreset", 0, 10'h000, 3'b111, 1'b0);
    for (int i = 1; i < 3; i++) begin
      tick();
      check("midreset", i, 10'h000, 3'b111, 1'b0);
    end
    reset = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      tick();
      check("postreset", e, (e == 6) ? 10'h080 : 10'h000, 3'b111, (e >= 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
